serial_rx_deframer: RTL and testbench
=====================================

# serial_rx_deframer

Byte receiver for the serial link: takes the raw asynchronous line from IN_SERIAL_RX, rebuilds 8N1 frames (1 start bit, 8 data bits LSB-first, 1 stop bit) and queues the bytes in a small FIFO. It sits directly between the board RX pin and the command/packet logic inside ProjectPon_VCentury. It presents bytes on a valid/ready handshake and reports framing and overrun errors as single-cycle pulses.

## Interface
- BAUD_DIV, 217 — clock cycles per bit (25 MHz / 115200); must be ≥ 4.
- FIFO_DEPTH, 4 — byte queue depth; must be a power of two, ≥ 2.
- CLK  in  1  system clock (25 MHz), rising edge.
- IN_PB_RESET  in  1  reset: one clock; reset is synchronous and active-low.
- IN_SERIAL_RX  in  1  asynchronous serial line, idle high.
- IN_READY  in  1  consumer accepts the head byte this cycle.
- OUT_DATA  out  8  FIFO head byte; reset 0; don't-care while OUT_VALID=0.
- OUT_VALID  out  1  FIFO non-empty; reset 0.
- OUT_FRAME_ERR  out  1  one-cycle pulse on a bad stop bit; reset 0.
- OUT_OVERRUN  out  1  one-cycle pulse when a good byte is dropped because the FIFO is full; reset 0.

## Operation
- Input path: 2-FF synchronizer on IN_SERIAL_RX. Both FFs reset to 1. All FSM decisions use the second FF output (rx_s).
- FSM states: WAIT_HIGH, IDLE, START, DATA, STOP.
- Reset state is WAIT_HIGH. Reset clears the FIFO (pointers, count), bit counter and cycle counter.
- WAIT_HIGH: go to IDLE on the first cycle rx_s=1. This prevents a false start when reset releases mid-frame or during a break.
- IDLE: if rx_s=0, go to START and clear the cycle counter.
- START: count to BAUD_DIV/2 (integer division), then sample rx_s.
  - 0 → go to DATA, bit index 0.
  - 1 → glitch; return to IDLE with no error.
- DATA: sample every BAUD_DIV cycles. Shift the sample into bit[index] (LSB first). After bit 7 go to STOP.
- STOP: sample after BAUD_DIV more cycles.
  - rx_s=1: push the byte, or pulse OUT_OVERRUN if the FIFO is full. Go to IDLE the next cycle, so back-to-back frames are accepted.
  - rx_s=0: pulse OUT_FRAME_ERR, discard the byte, go to WAIT_HIGH.
- FIFO behaviour:
  - Pop when OUT_VALID && IN_READY.
  - Push and pop in the same cycle are both honoured, including when the FIFO is full (no overrun) and when it is empty-then-push (count unchanged = 1 is not possible; empty push+pop cannot occur since pop needs valid).
  - Pointers wrap modulo FIFO_DEPTH. Count width is log2(FIFO_DEPTH)+1.
- No parity checking and no break reporting beyond the frame error.

## Timing
- Let t0 be the first cycle rx_s=0 in IDLE. The line edge reaches rx_s 2 cycles after it reaches the pin.
- Start-bit sample: t0 + BAUD_DIV/2.
- Data bit i sample: t0 + BAUD_DIV/2 + (i+1)·BAUD_DIV.
- Stop sample: t0 + BAUD_DIV/2 + 9·BAUD_DIV.
- Push happens on the stop-sample cycle. OUT_VALID and OUT_DATA update on the next rising edge (1-cycle registered latency).
- Error pulses are asserted exactly one cycle, on the cycle after the stop sample.
- After a pop, OUT_VALID/OUT_DATA reflect the next entry on the following edge.
- Reset low mid-frame: the next edge forces every output to its reset value. The partial byte is lost.
- Baud tolerance: ±2% cumulative mismatch must still sample within the middle half of each bit.

## Test plan
- Basic receive (BAUD_DIV=8, ideal bit timing): send 0xA5 with IN_READY=1 → OUT_VALID high for exactly 1 cycle with OUT_DATA=0xA5, 1 cycle after the stop sample; no error pulses.
- Back-to-back frames: send 0x00, 0xFF, 0x3C with no idle gap and IN_READY=0 → after 3 frames OUT_VALID=1. Popping yields 0x00, 0xFF, 0x3C in order, then OUT_VALID=0.
- Overrun: IN_READY=0, send 5 bytes 0x01..0x05 (FIFO_DEPTH=4) → one OUT_OVERRUN pulse at the 5th stop sample; FIFO holds 0x01..0x04.
  - Repeat with IN_READY asserted on the 5th stop-sample cycle → no overrun; the 5th byte is retained.
- Framing error: send 0x5A with stop bit 0, hold the line low 20 bits, then release → one OUT_FRAME_ERR pulse; no byte pushed; no new frame starts until the line goes high; the next good frame 0x11 is received correctly.
- Glitch rejection: a 2-cycle low pulse on an idle line → no start, no output, no error.
- Reset mid-operation: assert reset during data bit 3 while the line stays low → outputs read 0. After release the block sits in WAIT_HIGH until the line goes high; the following frame 0xC3 is received intact.

Source files
------------

// File: rtl/serial_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : serial_rx_deframer
// Brief    : 8N1 serial byte receiver with a small byte FIFO, valid/ready
//            output handshake and single-cycle framing/overrun error pulses.
// Revision : 1.0 - initial release
// ============================================================================
module serial_rx_deframer #(
    parameter int BAUD_DIV   = 217,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       CLK,
    input  logic       IN_PB_RESET,
    input  logic       IN_SERIAL_RX,
    input  logic       IN_READY,
    output logic [7:0] OUT_DATA,
    output logic       OUT_VALID,
    output logic       OUT_FRAME_ERR,
    output logic       OUT_OVERRUN
);

    localparam int c_cnt_w = $clog2(BAUD_DIV);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);

    localparam logic [c_cnt_w-1:0] c_half_last = c_cnt_w'(BAUD_DIV / 2 - 1);
    localparam logic [c_cnt_w-1:0] c_bit_last  = c_cnt_w'(BAUD_DIV - 1);
    localparam logic [c_ptr_w:0]   c_full      = (c_ptr_w + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_WAIT_HIGH = 3'd0,
        S_IDLE      = 3'd1,
        S_START     = 3'd2,
        S_DATA      = 3'd3,
        S_STOP      = 3'd4
    } state_t;

    state_t               r_state;
    logic                 r_rx_meta;
    logic                 r_rx_s;
    logic [1:0]           r_primed;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [2:0]           r_bit_idx;
    logic [7:0]           r_shift;
    logic                 r_frame_err;
    logic                 r_overrun;

    logic [7:0]           r_mem [FIFO_DEPTH];
    logic [c_ptr_w-1:0]   r_wr_ptr;
    logic [c_ptr_w-1:0]   r_rd_ptr;
    logic [c_ptr_w:0]     r_count;

    logic                 w_stop_sample;
    logic                 w_push_req;
    logic                 w_full;
    logic                 w_pop;
    logic                 w_push;

    assign w_stop_sample = (r_state == S_STOP) && (r_cnt == c_bit_last);
    assign w_push_req    = w_stop_sample && r_rx_s;
    assign w_full        = (r_count == c_full);
    assign w_pop         = OUT_VALID && IN_READY;
    // A full FIFO still accepts the new byte when the head leaves in the same cycle.
    assign w_push        = w_push_req && (!w_full || w_pop);

    assign OUT_VALID     = (r_count != '0);
    assign OUT_DATA      = r_mem[r_rd_ptr];
    assign OUT_FRAME_ERR = r_frame_err;
    assign OUT_OVERRUN   = r_overrun;

    // Synchronizer and frame FSM. The synchronizer's reset value of 1 is not
    // real line data, so WAIT_HIGH ignores rx_s until two samples have passed.
    always_ff @(posedge CLK) begin
        if (!IN_PB_RESET) begin
            r_rx_meta   <= 1'b1;
            r_rx_s      <= 1'b1;
            r_primed    <= 2'b00;
            r_state     <= S_WAIT_HIGH;
            r_cnt       <= '0;
            r_bit_idx   <= 3'd0;
            r_shift     <= 8'h00;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_rx_meta   <= IN_SERIAL_RX;
            r_rx_s      <= r_rx_meta;
            r_primed    <= {r_primed[0], 1'b1};
            r_frame_err <= 1'b0;
            r_overrun   <= w_push_req && w_full && !w_pop;

            case (r_state)
                S_WAIT_HIGH: begin
                    if (r_primed[1] && r_rx_s) begin
                        r_state <= S_IDLE;
                    end
                end

                S_IDLE: begin
                    r_cnt <= '0;
                    if (!r_rx_s) begin
                        r_state <= S_START;
                    end
                end

                S_START: begin
                    if (r_cnt == c_half_last) begin
                        r_cnt     <= '0;
                        r_bit_idx <= 3'd0;
                        r_state   <= r_rx_s ? S_IDLE : S_DATA;
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end

                S_DATA: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_idx] <= r_rx_s;
                        if (r_bit_idx == 3'd7) begin
                            r_state <= S_STOP;
                        end else begin
                            r_bit_idx <= r_bit_idx + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end

                S_STOP: begin
                    if (r_cnt == c_bit_last) begin
                        r_cnt <= '0;
                        if (r_rx_s) begin
                            r_state <= S_IDLE;
                        end else begin
                            r_frame_err <= 1'b1;
                            r_state     <= S_WAIT_HIGH;
                        end
                    end else begin
                        r_cnt <= r_cnt + c_cnt_w'(1);
                    end
                end

                default: begin
                    r_state <= S_WAIT_HIGH;
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (!IN_PB_RESET) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= 8'h00;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= r_shift;
                r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + (c_ptr_w + 1)'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - (c_ptr_w + 1)'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_serial_rx_deframer.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_rx_deframer
// Brief    : Scenario bench for serial_rx_deframer with an expected-byte queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_serial_rx_deframer;

    localparam int BAUD_DIV   = 8;
    localparam int FIFO_DEPTH = 4;
    // Pin edge -> rx_s (2) + half bit + 9 bits to stop sample, +1 registered output.
    localparam int c_stop_lat = 2 + BAUD_DIV / 2 + 9 * BAUD_DIV + 1;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx    = 1'b1;
    logic       ready = 1'b0;
    logic [7:0] data;
    logic       valid;
    logic       frame_err;
    logic       overrun;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] got_q[$];
    int         got_cyc_q[$];
    int         got_rd    = 0;
    int         fe_cnt    = 0;
    int         fe_cyc    = 0;
    int         ov_cnt    = 0;
    int         ov_cyc    = 0;
    int         valid_cnt = 0;
    logic [7:0] exp_q[$];
    int         last_start = 0;

    serial_rx_deframer #(
        .BAUD_DIV   (BAUD_DIV),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) dut (
        .CLK           (clk),
        .IN_PB_RESET   (rst_n),
        .IN_SERIAL_RX  (rx),
        .IN_READY      (ready),
        .OUT_DATA      (data),
        .OUT_VALID     (valid),
        .OUT_FRAME_ERR (frame_err),
        .OUT_OVERRUN   (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Observer: records handshakes and pulses, never compares.
    always @(negedge clk) begin
        if (rst_n) begin
            if (valid) valid_cnt = valid_cnt + 1;
            if (valid && ready) begin
                got_q.push_back(data);
                got_cyc_q.push_back(cyc);
            end
            if (frame_err) begin
                fe_cnt = fe_cnt + 1;
                fe_cyc = cyc;
            end
            if (overrun) begin
                ov_cnt = ov_cnt + 1;
                ov_cyc = cyc;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout want completion");
        $fatal(1, "watchdog");
    end

    // Called at a rising-edge instant; each bit lasts exactly BAUD_DIV cycles.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic expect_byte);
        #1;
        rx         = 1'b0;
        last_start = cyc;
        if (expect_byte) exp_q.push_back(b);
        repeat (BAUD_DIV) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1;
            rx = b[i];
            repeat (BAUD_DIV) @(posedge clk);
        end
        #1;
        rx = stop_bit;
        repeat (BAUD_DIV) @(posedge clk);
    endtask

    task automatic drain();
        #1;
        ready = 1'b1;
        repeat (FIFO_DEPTH + 4) @(posedge clk);
        #1;
        ready = 1'b0;
        @(posedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rx    = 1'b1;
        ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_valid: got %b want 0", valid); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_data: got %02h want 00", data); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
        total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4 * BAUD_DIV) @(posedge clk);
    endtask

    task automatic test_basic();
        int v0, fe0, ov0, first;
        logic [7:0] e;
        #1;
        ready = 1'b1;
        @(posedge clk);
        v0 = valid_cnt; fe0 = fe_cnt; ov0 = ov_cnt; first = got_rd;
        send_frame(8'hA5, 1'b1, 1'b1);
        repeat (2 * BAUD_DIV) @(posedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_rd >= got_q.size()) begin bad++; $display("FAIL basic_byte: got none want %02h", e); end
            else begin
                if (got_q[got_rd] !== e) begin bad++; $display("FAIL basic_byte: got %02h want %02h", got_q[got_rd], e); end
                got_rd++;
            end
        end
        total++;
        if (got_q.size() > first) begin
            if (got_cyc_q[first] != last_start + c_stop_lat) begin
                bad++; $display("FAIL basic_latency: got cycle %0d want %0d", got_cyc_q[first], last_start + c_stop_lat);
            end
        end else begin
            bad++; $display("FAIL basic_latency: got no output want cycle %0d", last_start + c_stop_lat);
        end
        total++; if (valid_cnt - v0 != 1) begin bad++; $display("FAIL basic_valid_cycles: got %0d want 1", valid_cnt - v0); end
        total++; if (fe_cnt - fe0 != 0) begin bad++; $display("FAIL basic_frame_err: got %0d want 0", fe_cnt - fe0); end
        total++; if (ov_cnt - ov0 != 0) begin bad++; $display("FAIL basic_overrun: got %0d want 0", ov_cnt - ov0); end
        total++; if (got_q.size() != got_rd) begin bad++; $display("FAIL basic_extra: got %0d bytes want %0d", got_q.size(), got_rd); end
    endtask

    task automatic test_back_to_back();
        logic [7:0] e;
        #1;
        ready = 1'b0;
        @(posedge clk);
        send_frame(8'h00, 1'b1, 1'b1);
        send_frame(8'hFF, 1'b1, 1'b1);
        send_frame(8'h3C, 1'b1, 1'b1);
        repeat (2 * BAUD_DIV) @(posedge clk);
        @(negedge clk);
        total++; if (valid !== 1'b1) begin bad++; $display("FAIL b2b_valid: got %b want 1", valid); end
        @(posedge clk);
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_rd >= got_q.size()) begin bad++; $display("FAIL b2b_byte: got none want %02h", e); end
            else begin
                if (got_q[got_rd] !== e) begin bad++; $display("FAIL b2b_byte: got %02h want %02h", got_q[got_rd], e); end
                got_rd++;
            end
        end
        total++; if (got_q.size() != got_rd) begin bad++; $display("FAIL b2b_extra: got %0d bytes want %0d", got_q.size(), got_rd); end
        @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL b2b_empty: got %b want 0", valid); end
        @(posedge clk);
    endtask

    task automatic test_overrun();
        int ov0, fe0, s5;
        logic [7:0] e;
        #1;
        ready = 1'b0;
        @(posedge clk);
        ov0 = ov_cnt; fe0 = fe_cnt;
        for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, 1'b1);
        send_frame(8'h05, 1'b1, 1'b0);
        s5 = last_start;
        repeat (2 * BAUD_DIV) @(posedge clk);
        total++; if (ov_cnt - ov0 != 1) begin bad++; $display("FAIL overrun_count: got %0d want 1", ov_cnt - ov0); end
        total++; if (ov_cyc != s5 + c_stop_lat) begin bad++; $display("FAIL overrun_cycle: got %0d want %0d", ov_cyc, s5 + c_stop_lat); end
        total++; if (fe_cnt - fe0 != 0) begin bad++; $display("FAIL overrun_frame_err: got %0d want 0", fe_cnt - fe0); end
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_rd >= got_q.size()) begin bad++; $display("FAIL overrun_byte: got none want %02h", e); end
            else begin
                if (got_q[got_rd] !== e) begin bad++; $display("FAIL overrun_byte: got %02h want %02h", got_q[got_rd], e); end
                got_rd++;
            end
        end
        total++; if (got_q.size() != got_rd) begin bad++; $display("FAIL overrun_extra: got %0d bytes want %0d", got_q.size(), got_rd); end

        // Full FIFO, but the consumer pops on the 5th stop-sample cycle.
        ov0 = ov_cnt;
        for (int k = 1; k <= 4; k++) send_frame(8'(k), 1'b1, 1'b1);
        fork
            send_frame(8'h05, 1'b1, 1'b1);
            begin
                #2;
                repeat (c_stop_lat - 1) @(posedge clk);
                #1;
                ready = 1'b1;
                @(posedge clk);
                #1;
                ready = 1'b0;
            end
        join
        repeat (2 * BAUD_DIV) @(posedge clk);
        total++; if (ov_cnt - ov0 != 0) begin bad++; $display("FAIL overrun_pop_same_cycle: got %0d pulses want 0", ov_cnt - ov0); end
        drain();
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_rd >= got_q.size()) begin bad++; $display("FAIL overrun_keep_byte: got none want %02h", e); end
            else begin
                if (got_q[got_rd] !== e) begin bad++; $display("FAIL overrun_keep_byte: got %02h want %02h", got_q[got_rd], e); end
                got_rd++;
            end
        end
        total++; if (got_q.size() != got_rd) begin bad++; $display("FAIL overrun_keep_extra: got %0d bytes want %0d", got_q.size(), got_rd); end
    endtask

    task automatic test_frame_err();
        int fe0, ov0, s, n0;
        logic [7:0] e;
        #1;
        ready = 1'b1;
        @(posedge clk);
        fe0 = fe_cnt; ov0 = ov_cnt; n0 = got_q.size();
        send_frame(8'h5A, 1'b0, 1'b0);
        s = last_start;
        repeat (20 * BAUD_DIV) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (3 * BAUD_DIV) @(posedge clk);
        total++; if (fe_cnt - fe0 != 1) begin bad++; $display("FAIL frame_err_count: got %0d want 1", fe_cnt - fe0); end
        total++; if (fe_cyc != s + c_stop_lat) begin bad++; $display("FAIL frame_err_cycle: got %0d want %0d", fe_cyc, s + c_stop_lat); end
        total++; if (got_q.size() != n0) begin bad++; $display("FAIL frame_err_no_byte: got %0d bytes want %0d", got_q.size(), n0); end
        send_frame(8'h11, 1'b1, 1'b1);
        repeat (2 * BAUD_DIV) @(posedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_rd >= got_q.size()) begin bad++; $display("FAIL frame_err_next_byte: got none want %02h", e); end
            else begin
                if (got_q[got_rd] !== e) begin bad++; $display("FAIL frame_err_next_byte: got %02h want %02h", got_q[got_rd], e); end
                got_rd++;
            end
        end
        total++; if (fe_cnt - fe0 != 1) begin bad++; $display("FAIL frame_err_after: got %0d want 1", fe_cnt - fe0); end
        total++; if (ov_cnt - ov0 != 0) begin bad++; $display("FAIL frame_err_overrun: got %0d want 0", ov_cnt - ov0); end
    endtask

    task automatic test_glitch();
        int v0, fe0, n0;
        logic [7:0] e;
        #1;
        ready = 1'b1;
        @(posedge clk);
        v0 = valid_cnt; fe0 = fe_cnt; n0 = got_q.size();
        #1;
        rx = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rx = 1'b1;
        repeat (12 * BAUD_DIV) @(posedge clk);
        total++; if (valid_cnt - v0 != 0) begin bad++; $display("FAIL glitch_valid: got %0d cycles want 0", valid_cnt - v0); end
        total++; if (fe_cnt - fe0 != 0) begin bad++; $display("FAIL glitch_frame_err: got %0d want 0", fe_cnt - fe0); end
        total++; if (got_q.size() != n0) begin bad++; $display("FAIL glitch_byte: got %0d bytes want %0d", got_q.size(), n0); end
        send_frame(8'h7E, 1'b1, 1'b1);
        repeat (2 * BAUD_DIV) @(posedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_rd >= got_q.size()) begin bad++; $display("FAIL glitch_recover: got none want %02h", e); end
            else begin
                if (got_q[got_rd] !== e) begin bad++; $display("FAIL glitch_recover: got %02h want %02h", got_q[got_rd], e); end
                got_rd++;
            end
        end
    endtask

    task automatic test_reset_mid();
        int v0, fe0;
        logic [7:0] e;
        #1;
        ready = 1'b0;
        @(posedge clk);
        send_frame(8'h99, 1'b1, 1'b0);
        repeat (2 * BAUD_DIV) @(posedge clk);
        @(negedge clk);
        total++; if (valid !== 1'b1 || data !== 8'h99) begin bad++; $display("FAIL reset_mid_pre: got valid=%b data=%02h want 1/99", valid, data); end
        @(posedge clk);
        #1;
        rx = 1'b0;
        repeat (4 * BAUD_DIV + BAUD_DIV / 2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        total++; if (valid !== 1'b0) begin bad++; $display("FAIL reset_mid_valid: got %b want 0", valid); end
        total++; if (data !== 8'h00) begin bad++; $display("FAIL reset_mid_data: got %02h want 00", data); end
        total++; if (frame_err !== 1'b0 || overrun !== 1'b0) begin bad++; $display("FAIL reset_mid_pulses: got %b%b want 00", frame_err, overrun); end
        rst_n = 1'b1;
        @(posedge clk);
        v0 = valid_cnt; fe0 = fe_cnt;
        repeat (15 * BAUD_DIV) @(posedge clk);
        total++; if (fe_cnt - fe0 != 0) begin bad++; $display("FAIL reset_mid_wait_high_err: got %0d want 0", fe_cnt - fe0); end
        total++; if (valid_cnt - v0 != 0) begin bad++; $display("FAIL reset_mid_wait_high_valid: got %0d want 0", valid_cnt - v0); end
        #1;
        rx    = 1'b1;
        ready = 1'b1;
        repeat (3 * BAUD_DIV) @(posedge clk);
        send_frame(8'hC3, 1'b1, 1'b1);
        repeat (2 * BAUD_DIV) @(posedge clk);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            total++;
            if (got_rd >= got_q.size()) begin bad++; $display("FAIL reset_mid_byte: got none want %02h", e); end
            else begin
                if (got_q[got_rd] !== e) begin bad++; $display("FAIL reset_mid_byte: got %02h want %02h", got_q[got_rd], e); end
                got_rd++;
            end
        end
        total++; if (fe_cnt - fe0 != 0) begin bad++; $display("FAIL reset_mid_frame_err: got %0d want 0", fe_cnt - fe0); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_overrun();
        test_frame_err();
        test_glitch();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
